// File: rtl/hub75_scan_driver.sv
// -----------------------------------------------------------------------------
// hub75_scan_driver
//
// Purpose:
//   Row-sequenced HUB75 LED-panel scan driver. For every scan row it shifts
//   COLS pixels into both panel halves, blanks the panel, latches the shifted
//   row, and then lets the panel display it while the next row is shifted.
//   The pixel data comes from a small built-in test-pattern generator. The
//   generator is isolated in one function, so a framebuffer read path can
//   replace it later without touching the timing FSM.
//
// Parameters:
//   COLS          pixels shifted per row per half (>= 2)
//   ROW_ADDR_W    row address width; scan rows = 2**ROW_ADDR_W
//   CLK_DIV       clk cycles per o_clk_out half-period (>= 1)
//   BLANK_CYCLES  cycles o_oe is held high before the latch pulse (>= 1)
//   ON_CYCLES     minimum cycles o_oe is low after the latch pulse (>= 1)
//   BAR_SHIFT     column bit index used by the bar pattern
//
// Ports:
//   i_clk         system clock
//   i_rst_n       synchronous active-low reset
//   i_en          run scanning
//   i_mode        pattern select (0 solid, 1 bars, 2 checker, 3 split)
//   i_color       {r,g,b} base colour
//   o_r0/o_g0/o_b0 upper-half pixel data
//   o_r1/o_g1/o_b1 lower-half pixel data
//   o_addr        row address presented to the panel
//   o_clk_out     panel shift clock
//   o_latch       panel latch, active high
//   o_oe          panel output enable, active low
//   o_frame_done  one-cycle pulse in the last display cycle of the last row
//
// Every output is a flop. Each output value is computed from the state the
// FSM held in the previous cycle, so the outputs trail the state register by
// exactly one clock.
// -----------------------------------------------------------------------------
module hub75_scan_driver #(
    parameter int COLS         = 64,
    parameter int ROW_ADDR_W   = 5,
    parameter int CLK_DIV      = 2,
    parameter int BLANK_CYCLES = 2,
    parameter int ON_CYCLES    = 16,
    parameter int BAR_SHIFT    = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [1:0]            i_mode,
    input  logic [2:0]            i_color,
    output logic                  o_r0,
    output logic                  o_g0,
    output logic                  o_b0,
    output logic                  o_r1,
    output logic                  o_g1,
    output logic                  o_b1,
    output logic [ROW_ADDR_W-1:0] o_addr,
    output logic                  o_clk_out,
    output logic                  o_latch,
    output logic                  o_oe,
    output logic                  o_frame_done
);

    // ------------------------------------------------------------------
    // Counter widths and terminal counts
    // ------------------------------------------------------------------
    localparam int COL_W   = $clog2(COLS);
    localparam int PH_W    = $clog2(2 * CLK_DIV);
    localparam int CNT_MAX = (BLANK_CYCLES > ON_CYCLES) ? BLANK_CYCLES : ON_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [COL_W-1:0]      COL_LAST   = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]      COL_ONE    = COL_W'(1);
    localparam logic [COL_W-1:0]      COL_ZERO   = COL_W'(0);
    localparam logic [PH_W-1:0]       PH_LAST    = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]       PH_RISE    = PH_W'(CLK_DIV);
    localparam logic [PH_W-1:0]       PH_ONE     = PH_W'(1);
    localparam logic [PH_W-1:0]       PH_ZERO    = PH_W'(0);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]      ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO   = CNT_W'(0);
    localparam logic [ROW_ADDR_W-1:0] ROW_LAST   = {ROW_ADDR_W{1'b1}};
    localparam logic [ROW_ADDR_W-1:0] ROW_ONE    = ROW_ADDR_W'(1);
    localparam logic [ROW_ADDR_W-1:0] ROW_ZERO   = ROW_ADDR_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_BLANK   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DISPLAY = 3'd4
    } state_t;

    state_t                  r_state;
    logic [COL_W-1:0]        r_col;
    logic [PH_W-1:0]         r_phase;
    logic [CNT_W-1:0]        r_cnt;       // shared by BLANK and DISPLAY
    logic [ROW_ADDR_W-1:0]   r_row;       // row currently being shifted
    logic                    r_valid;     // a latched row is on the panel
    logic [1:0]              r_mode;      // pattern select held for the row
    logic [2:0]              r_color;     // base colour held for the row
    logic [5:0]              w_pix;       // {r0,g0,b0,r1,g1,b1}

    // ------------------------------------------------------------------
    // Test-pattern generator: returns {upper, lower} for one column.
    // Bars take col[BAR_SHIFT+2:BAR_SHIFT]. When col is narrower than that
    // field, the zero-extension before the shift supplies the missing high
    // bits as 0.
    // ------------------------------------------------------------------
    function automatic logic [5:0] pix_pattern(
        input logic [1:0]       mode,
        input logic [2:0]       c,
        input logic [COL_W-1:0] col,
        input logic             row0
    );
        logic [2:0] bar;
        logic       hit;
        bar = 3'(32'(col) >> BAR_SHIFT);
        hit = col[0] ^ row0;
        case (mode)
            2'd0:    pix_pattern = {c, c};
            2'd1:    pix_pattern = {bar, bar};
            2'd2:    pix_pattern = hit ? {c, 3'b000} : {3'b000, c};
            2'd3:    pix_pattern = {c, ~c};
            default: pix_pattern = {c, c};
        endcase
    endfunction

    // Pixel value for the column being shifted.
    always_comb begin
        w_pix = pix_pattern(r_mode, r_color, r_col, r_row[0]);
    end

    // Scan FSM: counters, per-row sampled controls and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_col        <= COL_ZERO;
            r_phase      <= PH_ZERO;
            r_cnt        <= CNT_ZERO;
            r_row        <= ROW_ZERO;
            r_valid      <= 1'b0;
            r_mode       <= 2'd0;
            r_color      <= 3'd0;
            {o_r0, o_g0, o_b0, o_r1, o_g1, o_b1} <= 6'd0;
            o_addr       <= ROW_ZERO;
            o_clk_out    <= 1'b0;
            o_latch      <= 1'b0;
            o_oe         <= 1'b1;
            o_frame_done <= 1'b0;
        end else begin
            o_latch      <= 1'b0;
            o_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    o_oe      <= 1'b1;
                    o_clk_out <= 1'b0;
                    if (i_en) begin
                        r_state <= ST_SHIFT;
                        r_col   <= COL_ZERO;
                        r_phase <= PH_ZERO;
                        r_valid <= 1'b0;
                        r_mode  <= i_mode;
                        r_color <= i_color;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_SHIFT: begin
                    // The previous row stays lit while this one shifts in.
                    o_oe      <= ~r_valid;
                    // The rising edge falls mid-column, so data has been
                    // stable for CLK_DIV cycles when the panel samples it.
                    o_clk_out <= (r_phase >= PH_RISE);
                    {o_r0, o_g0, o_b0, o_r1, o_g1, o_b1} <= w_pix;
                    if (r_phase == PH_LAST) begin
                        r_phase <= PH_ZERO;
                        if (r_col == COL_LAST) begin
                            r_col   <= COL_ZERO;
                            r_cnt   <= CNT_ZERO;
                            r_state <= ST_BLANK;
                        end else begin
                            r_col <= r_col + COL_ONE;
                        end
                    end else begin
                        r_phase <= r_phase + PH_ONE;
                    end
                end

                ST_BLANK: begin
                    o_oe      <= 1'b1;
                    o_clk_out <= 1'b0;
                    // The panel is dark here, so the address can change safely.
                    o_addr    <= r_row;
                    if (r_cnt == BLANK_LAST) begin
                        r_cnt   <= CNT_ZERO;
                        r_state <= ST_LATCH;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                ST_LATCH: begin
                    o_oe      <= 1'b1;
                    o_clk_out <= 1'b0;
                    o_latch   <= 1'b1;
                    r_valid   <= 1'b1;
                    r_cnt     <= CNT_ZERO;
                    r_state   <= ST_DISPLAY;
                end

                ST_DISPLAY: begin
                    o_oe      <= 1'b0;
                    o_clk_out <= 1'b0;
                    if (r_cnt == ON_LAST) begin
                        r_cnt        <= CNT_ZERO;
                        r_row        <= r_row + ROW_ONE;
                        o_frame_done <= (r_row == ROW_LAST);
                        // i_en is only looked at here, so a row that is in
                        // progress always completes.
                        if (i_en) begin
                            r_state <= ST_SHIFT;
                            r_col   <= COL_ZERO;
                            r_phase <= PH_ZERO;
                            r_mode  <= i_mode;
                            r_color <= i_color;
                        end else begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    o_oe      <= 1'b1;
                    o_clk_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// -----------------------------------------------------------------------------
// Self-checking bench for hub75_scan_driver.
// Configuration: COLS=4, ROW_ADDR_W=2, CLK_DIV=1, BLANK_CYCLES=2, ON_CYCLES=3,
// BAR_SHIFT=0, which gives a 14-cycle row and a 56-cycle frame.
// A table of per-row pattern records comes first. Hand sequences for enable
// drop and mid-row reset follow. The last part is a randomized run checked
// against a row-offset reference model.
// -----------------------------------------------------------------------------
module tb_hub75_scan_driver;

    localparam int COLS = 4;
    localparam int RW   = 2;
    localparam int CD   = 1;
    localparam int BL   = 2;
    localparam int ON   = 3;
    localparam int BS   = 0;
    localparam int SH   = COLS * 2 * CD;
    localparam int P    = SH + BL + 1 + ON;
    localparam int NROW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic [1:0]    mode  = 2'd0;
    logic [2:0]    color = 3'd0;
    logic          o_r0, o_g0, o_b0, o_r1, o_g1, o_b1;
    logic [RW-1:0] o_addr;
    logic          o_clk_out, o_latch, o_oe, o_frame_done;

    hub75_scan_driver #(
        .COLS(COLS), .ROW_ADDR_W(RW), .CLK_DIV(CD),
        .BLANK_CYCLES(BL), .ON_CYCLES(ON), .BAR_SHIFT(BS)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_color(color),
        .o_r0(o_r0), .o_g0(o_g0), .o_b0(o_b0), .o_r1(o_r1), .o_g1(o_g1), .o_b1(o_b1),
        .o_addr(o_addr), .o_clk_out(o_clk_out), .o_latch(o_latch), .o_oe(o_oe),
        .o_frame_done(o_frame_done)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic prev_clk = 1'b0;
    logic rise     = 1'b0;

    typedef struct packed {
        logic [1:0]  mode;
        logic [2:0]  color;
        logic [11:0] up;   // upper {r0,g0,b0} for col c at [3c +: 3]
        logic [11:0] lo;   // lower {r1,g1,b1}
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rise     = o_clk_out & ~prev_clk;
        prev_clk = o_clk_out;
        cyc++;
    endtask

    task automatic wait_rise(input string name);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!rise && k < 40);
        chk(name, 32'(rise), 32'd1);
    endtask

    task automatic wait_latch(input string name, output int rises);
        int k;
        k = 0;
        rises = 0;
        do begin
            step();
            if (rise) rises++;
            k++;
        end while (!o_latch && k < 40);
        chk(name, 32'(o_latch), 32'd1);
    endtask

    function automatic logic [5:0] ref_pix(input int m, input logic [2:0] c,
                                           input int col, input int row);
        logic [2:0] bar;
        logic [2:0] zero3;
        zero3 = 3'd0;
        bar   = 3'((col >> BS) % 8);
        case (m)
            0:       ref_pix = {c, c};
            1:       ref_pix = {bar, bar};
            2:       ref_pix = (((col + row) % 2) == 1) ? {c, zero3} : {zero3, c};
            default: ref_pix = {c, ~c};
        endcase
    endfunction

    initial begin
        int       rises, lowcnt, last_fd, k;
        logic [2:0] fdv;
        // reference-model state
        bit         m_idle, m_valid;
        int         m_pos, m_row, m_mode, m_addr;
        logic [2:0] m_color;
        logic [5:0] e_ctl, e_data;
        bit         e_chkdata, rr, re;
        logic [1:0] rm;
        logic [2:0] rc;

        tbl[0] = '{mode: 2'd0, color: 3'b101, up: 12'b101_101_101_101, lo: 12'b101_101_101_101};
        tbl[1] = '{mode: 2'd1, color: 3'b011, up: 12'b011_010_001_000, lo: 12'b011_010_001_000};
        tbl[2] = '{mode: 2'd3, color: 3'b110, up: 12'b110_110_110_110, lo: 12'b001_001_001_001};
        tbl[3] = '{mode: 2'd2, color: 3'b111, up: 12'b000_111_000_111, lo: 12'b111_000_111_000};

        // ---- reset values, then first rising edge two cycles after IDLE exit
        rst_n = 1'b0; en = 1'b0; mode = tbl[0].mode; color = tbl[0].color;
        repeat (3) step();
        chk("reset outputs",
            {o_r0, o_g0, o_b0, o_r1, o_g1, o_b1, o_addr, o_clk_out, o_latch, o_oe, o_frame_done},
            {6'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        rst_n = 1'b1; en = 1'b1;
        step();  // IDLE sees en
        step();  // phase 0 of col 0
        chk("first col clk low", {o_clk_out, o_oe}, 2'b01);
        step();  // phase 1: rising edge
        chk("first rise timing", 32'(rise), 32'd1);

        // ---- table: one row per record, rows 0..3 of the first frame
        for (int e = 0; e < 4; e++) begin
            for (int c = 0; c < 4; c++) begin
                if (!(e == 0 && c == 0)) wait_rise("row rise");
                chk("upper pix", {o_r0, o_g0, o_b0}, tbl[e].up[3*c +: 3]);
                chk("lower pix", {o_r1, o_g1, o_b1}, tbl[e].lo[3*c +: 3]);
                chk("shift oe", 32'(o_oe), (e == 0) ? 32'd1 : 32'd0);
            end
            wait_latch("row latch", rises);
            chk("rises per row extra", 32'(rises), 32'd0);
            chk("addr at latch", 32'(o_addr), 32'(e));
            if (e < 3) begin
                mode  = tbl[e+1].mode;
                color = tbl[e+1].color;
            end
        end
        // row 3 display: frame_done only in the last of the 3 DISPLAY cycles
        lowcnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            fdv[i] = o_frame_done;
            if (!o_oe && !o_latch) lowcnt++;
        end
        chk("frame_done position", 32'(fdv), 32'b100);
        chk("display oe low", 32'(lowcnt), 32'd3);
        last_fd = cyc;
        k = 0;
        do begin step(); k++; end while (!o_frame_done && k < 120);
        chk("frame_done seen", 32'(o_frame_done), 32'd1);
        chk("frame period", 32'(cyc - last_fd), 32'd56);

        // ---- drop en during column 2: row completes, then IDLE
        wait_rise("b rise0");
        wait_rise("b rise1");
        wait_rise("b rise2");
        en = 1'b0;
        wait_latch("b latch", rises);
        chk("b addr", 32'(o_addr), 32'd0);
        lowcnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (!o_oe) lowcnt++;
        end
        chk("b display cycles", 32'(lowcnt), 32'd3);
        lowcnt = 0;
        rises  = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!o_oe) lowcnt++;
            if (rise) rises++;
        end
        chk("b idle oe low count", 32'(lowcnt), 32'd0);
        chk("b idle rises", 32'(rises), 32'd0);
        en = 1'b1;
        wait_rise("b restart rise");
        chk("b restart oe (valid=0)", 32'(o_oe), 32'd1);
        wait_latch("b row1 latch", rises);
        chk("b row1 addr", 32'(o_addr), 32'd1);

        // ---- reset mid-SHIFT at col 2 of row 2
        wait_rise("c rise0");
        wait_rise("c rise1");
        wait_rise("c rise2");
        mode = 2'd1; color = 3'd0;
        rst_n = 1'b0;
        step();
        chk("c reset ctl", {o_clk_out, o_oe, o_latch, o_addr}, {1'b0, 1'b1, 1'b0, 2'd0});
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            wait_rise("c resume rise");
            chk("c resume col", {o_r0, o_g0, o_b0}, 32'(c));
        end
        wait_latch("c resume latch", rises);
        chk("c resume row", 32'(o_addr), 32'd0);

        // ---- randomized run against the row-offset model
        m_idle = 1'b1; m_valid = 1'b0; m_pos = 0; m_row = 0; m_mode = 0; m_addr = 0;
        m_color = 3'd0;
        for (int n = 0; n < 3000; n++) begin
            rr = (n == 0) || ($urandom_range(63) == 0);
            re = ($urandom_range(7) != 0);
            rm = 2'($urandom_range(3));
            rc = 3'($urandom_range(7));
            rst_n = ~rr; en = re; mode = rm; color = rc;
            e_chkdata = 1'b0;
            e_data    = 6'd0;
            if (rr) begin
                e_ctl = {1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
                e_chkdata = 1'b1;
                m_idle = 1'b1; m_row = 0; m_valid = 1'b0; m_addr = 0;
            end else if (m_idle) begin
                e_ctl = {1'b0, 1'b0, 1'b1, 1'b0, 2'(m_addr)};
                if (re) begin
                    m_idle = 1'b0; m_pos = 0; m_valid = 1'b0; m_mode = int'(rm); m_color = rc;
                end
            end else begin
                if (m_pos < SH) begin
                    e_ctl = {1'((m_pos % (2*CD)) >= CD), 1'b0, ~m_valid, 1'b0, 2'(m_addr)};
                    e_chkdata = 1'b1;
                    e_data = ref_pix(m_mode, m_color, m_pos / (2*CD), m_row);
                end else if (m_pos < SH + BL) begin
                    m_addr = m_row;
                    e_ctl = {1'b0, 1'b0, 1'b1, 1'b0, 2'(m_addr)};
                end else if (m_pos == SH + BL) begin
                    e_ctl = {1'b0, 1'b1, 1'b1, 1'b0, 2'(m_addr)};
                    m_valid = 1'b1;
                end else begin
                    e_ctl = {1'b0, 1'b0, 1'b0, 1'(m_pos == P-1 && m_row == NROW-1), 2'(m_addr)};
                end
                if (m_pos == P-1) begin
                    m_row = (m_row + 1) % NROW;
                    if (re) begin
                        m_pos = 0; m_mode = int'(rm); m_color = rc;
                    end else begin
                        m_idle = 1'b1; m_valid = 1'b0;
                    end
                end else begin
                    m_pos++;
                end
            end
            step();
            chk("rand ctl", {o_clk_out, o_latch, o_oe, o_frame_done, o_addr}, e_ctl);
            if (e_chkdata) chk("rand pix", {o_r0, o_g0, o_b0, o_r1, o_g1, o_b1}, e_data);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hub75_scan_driver.md
Name: hub75_scan_driver

Overview:
- Parametrised HUB75 LED-panel scan driver that replaces the fixed free-running test-pattern generator.
- Runs a proper row sequence: shift COLS pixels, blank, latch, display, advance the row address.
- Generates selectable test patterns for both panel halves.
- Sits between the top level and the panel connector pins; a later framebuffer can replace the pattern logic without changing the timing FSM.

Parameters:
- COLS, 64: pixels shifted per row per half; must be ≥ 2.
- ROW_ADDR_W, 5: width of addr; scan rows = 2**ROW_ADDR_W.
- CLK_DIV, 2: clk cycles per clk_out half-period; must be ≥ 1.
- BLANK_CYCLES, 2: cycles oe is held high before latch; must be ≥ 1.
- ON_CYCLES, 16: minimum cycles oe is low after latch; must be ≥ 1.
- BAR_SHIFT, 3: column bit index used by the bar pattern.

Ports:
- clk, input, 1: single system clock.
- rst_n, input, 1: synchronous active-low reset.
- en, input, 1: run scanning.
- mode, input, 2: pattern select.
- color, input, 3: {r,g,b} base colour.
- r0 g0 b0, output, 1 each: upper-half pixel data.
- r1 g1 b1, output, 1 each: lower-half pixel data.
- addr, output, ROW_ADDR_W: row address.
- clk_out, output, 1: panel shift clock.
- latch, output, 1: panel latch, active high.
- oe, output, 1: panel output enable, active low.
- frame_done, output, 1: one-cycle pulse at frame end.

Behaviour:
- Reset (rst_n=0 sampled on posedge clk):
  - FSM goes to IDLE; row=0, col=0.
  - Outputs: rgb=0, addr=0, clk_out=0, latch=0, oe=1, frame_done=0, valid=0.
  - Applies identically mid-row.
- All outputs are registered.
- FSM states: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE:
  - oe=1, clk_out=0, latch=0.
  - en=1 → SHIFT with col=0 and valid=0.
- SHIFT:
  - Per column, phase counts 0 … 2*CLK_DIV−1.
  - At phase 0, pixel data is driven and clk_out=0. clk_out=1 for phases CLK_DIV … 2*CLK_DIV−1.
  - The rising edge falls mid-column, so data is stable for CLK_DIV cycles before it.
  - After the last phase of col=COLS−1: clk_out=0, go to BLANK.
  - oe=0 during SHIFT only if valid=1 (the previous row is still displayed); otherwise oe=1.
- BLANK:
  - oe=1 for BLANK_CYCLES.
  - addr is loaded with the shifted row on the first BLANK cycle.
- LATCH:
  - latch=1 for exactly 1 cycle, oe=1.
  - Sets valid=1.
- DISPLAY:
  - oe=0 for ON_CYCLES.
  - Row increments modulo 2**ROW_ADDR_W.
  - On wrap from the last row to 0, frame_done=1 for the final DISPLAY cycle.
  - Next state is SHIFT if en=1, else IDLE (oe returns to 1).
- en deasserted mid-row: the current row completes through DISPLAY, then IDLE.
- Row period: COLS*2*CLK_DIV + BLANK_CYCLES + 1 + ON_CYCLES cycles.
- mode and color are sampled at SHIFT entry and held for the whole row; changes mid-row take effect next row.
- Patterns (upper {r0,g0,b0} / lower {r1,g1,b1}, where c = sampled color, col = current column):
  - mode 0: solid — both halves = c.
  - mode 1: bars — both halves = col[BAR_SHIFT+2:BAR_SHIFT]; missing high bits of col read as 0.
  - mode 2: checker — c if col[0] XOR row[0], else 0; lower half uses the inverted result.
  - mode 3: split — upper = c, lower = ~c.
- Counter widths: col is clog2(COLS) bits; phase is clog2(2*CLK_DIV) bits. No overflow beyond the stated terminal counts.

Test Plan:
Bench configuration: COLS=4, ROW_ADDR_W=2, CLK_DIV=1, BLANK_CYCLES=2, ON_CYCLES=3, which gives a 14-cycle row period.
- Hold rst_n=0 for 3 cycles, then en=1 → outputs at reset values during reset; the first clk_out rising edge occurs 2 cycles after IDLE exit; oe=1 throughout the first SHIFT (valid=0).
- Run one row with mode 0, color=3'b101 → exactly 4 clk_out rising edges with r0=1 g0=0 b0=1 r1=1 g1=0 b1=1 at each; addr=0 during BLANK; latch high for 1 cycle; oe low 3 cycles.
- Run a full frame → addr sequence 0,1,2,3; frame_done pulses once per 56 cycles, in the last cycle of row 3's DISPLAY; oe=0 during the SHIFT of rows after the first.
- mode 1 with BAR_SHIFT=0 → upper data at successive rising edges = 000, 001, 010, 011; mode 3 with color=3'b110 → lower half = 001.
- Drop en during column 2 of a row → the row completes (latch asserted, 3 DISPLAY cycles), then IDLE with oe=1 and no further clk_out edges; reassert en → restart with valid=0.
- Assert rst_n=0 mid-SHIFT at col=2 → next cycle clk_out=0, oe=1, addr=0; after release, scanning resumes from row 0, col 0.
